// File: rtl/tych_tx_arb.sv
// Packet-atomic round-robin arbiter: NUM_REQ Avalon-ST sources share one MAC TX port.
// An owner keeps the port until its eop beat is accepted; the output has a 1-deep register stage.
module tych_tx_arb #(
  parameter int NUM_REQ = 2,
  parameter int DWIDTH  = 512,
  parameter int EWIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        en_mask,
  input  logic                      err_clr,
  input  logic [NUM_REQ*DWIDTH-1:0] in_data,
  input  logic [NUM_REQ*EWIDTH-1:0] in_empty,
  input  logic [NUM_REQ-1:0]        in_sop,
  input  logic [NUM_REQ-1:0]        in_eop,
  input  logic [NUM_REQ-1:0]        in_valid,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic [DWIDTH-1:0]         out_data,
  output logic [EWIDTH-1:0]         out_empty,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        proto_err,
  output logic [NUM_REQ*32-1:0]     pkt_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  r_state;
  logic [NUM_REQ-1:0]      r_grant;
  logic [PW-1:0]           r_owner;
  logic [PW-1:0]           r_rr_ptr;
  logic [DWIDTH-1:0]       r_out_data;
  logic [EWIDTH-1:0]       r_out_empty;
  logic                    r_out_sop;
  logic                    r_out_eop;
  logic                    r_out_valid;
  logic [NUM_REQ-1:0]      r_proto_err;
  logic [NUM_REQ*32-1:0]   r_pkt_cnt;

  logic [NUM_REQ-1:0]      w_cand;
  logic                    w_pick_vld;
  logic [PW-1:0]           w_pick;
  logic [NUM_REQ-1:0]      w_drop;
  logic                    w_acc;
  logic                    w_eop_acc;
  logic [DWIDTH-1:0]       w_sel_data;
  logic [EWIDTH-1:0]       w_sel_empty;
  logic                    w_sel_sop;
  logic                    w_sel_eop;
  logic                    w_sel_valid;

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  assign w_cand = in_valid & in_sop & en_mask;

  // Descending scan with overwrite leaves the first hit in rotated order.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand[rot(r_rr_ptr, k)]) begin
        w_pick_vld = 1'b1;
        w_pick     = rot(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_sel_data  = '0;
    w_sel_empty = '0;
    w_sel_sop   = 1'b0;
    w_sel_eop   = 1'b0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PW'(i)) begin
        w_sel_data  = in_data[i*DWIDTH +: DWIDTH];
        w_sel_empty = in_empty[i*EWIDTH +: EWIDTH];
        w_sel_sop   = in_sop[i];
        w_sel_eop   = in_eop[i];
        w_sel_valid = in_valid[i];
      end
    end
  end

  // Non-owner mid-packet beats are swallowed so a stray source cannot stall forever.
  always_comb begin
    w_drop   = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_drop[i] = rst & in_valid[i] & ~in_sop[i] &
                  ~((r_state == LOCKED) && (r_owner == PW'(i)));
    end
    in_ready = w_drop;
    if (rst && r_state == LOCKED) in_ready[r_owner] = ~r_out_valid | out_ready;
  end

  assign w_acc     = (r_state == LOCKED) & w_sel_valid & (~r_out_valid | out_ready);
  assign w_eop_acc = w_acc & w_sel_eop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_out_data  <= '0;
      r_out_empty <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_valid <= 1'b0;
      r_proto_err <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      r_proto_err <= (r_proto_err & ~{NUM_REQ{err_clr}}) | w_drop;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state <= LOCKED;
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
          end
        end
        LOCKED: begin
          if (w_eop_acc) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= rot(r_owner, 1);
          end
        end
        default: r_state <= IDLE;
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_eop_acc && r_owner == PW'(i)) r_pkt_cnt[i*32 +: 32] <= r_pkt_cnt[i*32 +: 32] + 32'd1;
      end
      if (w_acc) begin
        r_out_data  <= w_sel_data;
        r_out_empty <= w_sel_empty;
        r_out_sop   <= w_sel_sop;
        r_out_eop   <= w_sel_eop;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_empty = r_out_empty;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign out_valid = r_out_valid;
  assign grant     = r_grant;
  assign proto_err = r_proto_err;
  assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_tych_tx_arb.sv
// Directed bench for tych_tx_arb: reset, fairness, backpressure, single-beat, drop/err, mask and wrap.
// Beat payload low bits carry {requester, tag, beat index} so the monitor can check order.
module tb_tych_tx_arb;
  localparam int NR = 2;
  localparam int DW = 512;
  localparam int EW = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    en_mask = 2'b11;
  logic             err_clr = 1'b0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR*EW-1:0] in_empty = '0;
  logic [NR-1:0]    in_sop = '0;
  logic [NR-1:0]    in_eop = '0;
  logic [NR-1:0]    in_valid = '0;
  logic [NR-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic [EW-1:0]    out_empty;
  logic             out_sop;
  logic             out_eop;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    proto_err;
  logic [NR*32-1:0] pkt_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt[NR];
  int seq_err = 0;
  int nbeats = 0;
  int cur = -1;
  int lastb = 0;
  int ord[$];
  int g0_hits = 0;
  logic g0_watch = 1'b0;

  tych_tx_arb #(.NUM_REQ(NR), .DWIDTH(DW), .EWIDTH(EW)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .err_clr(err_clr),
    .in_data(in_data), .in_empty(in_empty), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_empty(out_empty), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkbeat(input int r, input logic [7:0] tag, input int b);
    return {{(DW-24){1'b0}}, 8'(r), tag, 8'(b)};
  endfunction

  // Output monitor: sampled mid-cycle, records beats that will be accepted on the next edge.
  always @(negedge clk) begin
    #2;
    if (rst && out_valid && out_ready) begin
      nbeats++;
      if (out_sop) begin
        cur = int'(out_data[23:16]);
        ord.push_back(cur);
        if (out_data[7:0] != 8'd0) seq_err++;
      end else if (int'(out_data[23:16]) != cur || int'(out_data[7:0]) != lastb + 1) begin
        seq_err++;
      end
      lastb = int'(out_data[7:0]);
    end
    if (g0_watch && grant[0]) g0_hits++;
  end

  task automatic send_pkt(input int r, input int nb, input logic [7:0] tag, input logic [EW-1:0] emp);
    int b;
    int guard;
    b = 0;
    guard = 0;
    while (b < nb && guard < 500) begin
      @(negedge clk);
      in_valid[r] = 1'b1;
      in_sop[r]   = (b == 0);
      in_eop[r]   = (b == nb - 1);
      in_data[r*DW +: DW]  = mkbeat(r, tag, b);
      in_empty[r*EW +: EW] = (b == nb - 1) ? emp : '0;
      #2;
      if (in_ready[r]) b++;
      guard++;
    end
    if (b < nb) chk("send_timeout", 64'(b), 64'(nb));
    else exp_cnt[r]++;
  endtask

  task automatic rel(input int r);
    @(negedge clk);
    in_valid[r] = 1'b0;
    in_sop[r]   = 1'b0;
    in_eop[r]   = 1'b0;
  endtask

  task automatic wait_grant(input logic [NR-1:0] g, input string tag);
    int n;
    n = 0;
    while (grant !== g && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(tag, 64'(grant), 64'(g));
  endtask

  initial begin
    int b;
    int gd;
    int nb0;
    logic found;
    logic [DW-1:0] cap;
    logic [31:0] ewrap;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", pkt_cnt, 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // T1: abandon a packet with an asynchronous reset
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_sop[0] = 1'b1;
    in_data[0 +: DW] = mkbeat(0, 8'h10, 0);
    b = 0;
    gd = 0;
    while (b < 4 && gd < 50) begin
      #2;
      if (in_ready[0]) b++;
      @(negedge clk);
      in_sop[0] = (b == 0);
      in_data[0 +: DW] = mkbeat(0, 8'h10, b);
      gd++;
    end
    #2;
    chk("t1_pre_valid", 64'(out_valid), 64'd1);
    chk("t1_pre_grant", 64'(grant), 64'd1);
    rst = 1'b0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_data", 64'(out_data[63:0]), 64'd0);
    chk("t1_sop", 64'(out_sop), 64'd0);
    chk("t1_grant", 64'(grant), 64'd0);
    chk("t1_ready", 64'(in_ready), 64'd0);
    chk("t1_cnt", pkt_cnt, 64'd0);
    in_valid = '0;
    in_sop = '0;
    in_eop = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("t1_post_grant", 64'(grant), 64'd0);
    chk("t1_post_valid", 64'(out_valid), 64'd0);

    // T2: fairness with back-to-back packets from both sources
    ord.delete();
    fork
      begin
        for (int p = 0; p < 3; p++) send_pkt(0, 4, 8'(8'h20 + p), '0);
        rel(0);
      end
      begin
        for (int p = 0; p < 3; p++) send_pkt(1, 4, 8'(8'h28 + p), '0);
        rel(1);
      end
    join
    repeat (3) @(negedge clk);
    #2;
    chk("t2_npkts", 64'(ord.size()), 64'd6);
    for (int i = 0; i < 6 && i < ord.size(); i++) chk("t2_order", 64'(ord[i]), 64'(i % 2));
    chk("t2_cnt0", 64'(pkt_cnt[31:0]), 64'(exp_cnt[0]));
    chk("t2_cnt1", 64'(pkt_cnt[63:32]), 64'(exp_cnt[1]));

    // T3: backpressure mid-packet
    nb0 = nbeats;
    fork
      begin
        send_pkt(0, 6, 8'h30, '0);
        rel(0);
      end
      begin
        found = 1'b0;
        gd = 0;
        while (!found && gd < 100) begin
          @(negedge clk);
          #2;
          if (out_valid && out_data[15:8] == 8'h30 && out_data[7:0] == 8'd2) found = 1'b1;
          gd++;
        end
        if (!found) chk("t3_timeout", 64'd0, 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        cap = out_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #2;
          chk("t3_hold_data", 64'(out_data[63:0] ^ cap[63:0]), 64'd0);
          chk("t3_hold_valid", 64'(out_valid), 64'd1);
          chk("t3_in_ready", 64'(in_ready[0]), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    #2;
    chk("t3_beats", 64'(nbeats - nb0), 64'd6);
    chk("t3_cnt0", 64'(pkt_cnt[31:0]), 64'(exp_cnt[0]));

    // T4: single-beat packet with empty=13
    send_pkt(1, 1, 8'h40, 6'd13);
    rel(1);
    #2;
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_sop", 64'(out_sop), 64'd1);
    chk("t4_eop", 64'(out_eop), 64'd1);
    chk("t4_empty", 64'(out_empty), 64'd13);
    chk("t4_tag", 64'(out_data[15:8]), 64'h40);
    chk("t4_cnt1", 64'(pkt_cnt[63:32]), 64'(exp_cnt[1]));

    // T5: stray beat from non-owner is dropped and flagged
    fork
      begin
        send_pkt(1, 4, 8'h50, '0);
        rel(1);
      end
      begin
        wait_grant(2'b10, "t5_grant");
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_sop[0] = 1'b0;
        in_data[0 +: DW] = mkbeat(0, 8'h5F, 7);
        #2;
        chk("t5_drop_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #2;
        chk("t5_perr", 64'(proto_err), 64'b01);
      end
    join
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    chk("t5_clr", 64'(proto_err), 64'd0);
    @(negedge clk);
    err_clr = 1'b1;
    in_valid[0] = 1'b1;
    in_sop[0] = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    in_valid[0] = 1'b0;
    #2;
    chk("t5_set_prio", 64'(proto_err), 64'b01);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    chk("t5_clr2", 64'(proto_err), 64'd0);

    // T6: masked requester never granted, then mask drop mid-packet
    en_mask = 2'b10;
    g0_hits = 0;
    g0_watch = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_sop[0] = 1'b1;
    in_data[0 +: DW] = mkbeat(0, 8'h60, 0);
    send_pkt(1, 2, 8'h61, '0);
    send_pkt(1, 2, 8'h62, '0);
    rel(1);
    repeat (3) @(negedge clk);
    #2;
    chk("t6_g0_hits", 64'(g0_hits), 64'd0);
    chk("t6_idle_grant", 64'(grant), 64'd0);
    chk("t6_mask_ready", 64'(in_ready[0]), 64'd0);
    g0_watch = 1'b0;
    rel(0);
    en_mask = 2'b11;
    fork
      begin
        send_pkt(0, 3, 8'h63, '0);
        rel(0);
      end
      begin
        wait_grant(2'b01, "t6_grant0");
        @(negedge clk);
        en_mask = 2'b10;
      end
    join
    repeat (2) @(negedge clk);
    #2;
    chk("t6_cnt0", 64'(pkt_cnt[31:0]), 64'(exp_cnt[0]));
    chk("t6_cnt1", 64'(pkt_cnt[63:32]), 64'(exp_cnt[1]));
    en_mask = 2'b11;

    // Counter wrap
    @(negedge clk);
    force dut.r_pkt_cnt = {32'hFFFF_FFFF, 32'(exp_cnt[0])};
    #1;
    release dut.r_pkt_cnt;
    #1;
    chk("wrap_pre", 64'(pkt_cnt[63:32]), 64'hFFFF_FFFF);
    ewrap = 32'hFFFF_FFFF;
    ewrap = ewrap + 32'd1;
    send_pkt(1, 1, 8'h70, '0);
    rel(1);
    #2;
    chk("wrap_cnt1", 64'(pkt_cnt[63:32]), 64'(ewrap));
    chk("wrap_cnt0", 64'(pkt_cnt[31:0]), 64'(exp_cnt[0]));

    repeat (3) @(negedge clk);
    chk("seq_errors", 64'(seq_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
